// File: rtl/mac_dot_sequencer.sv
// Sequencer that clears an external mac, feeds VEC_LEN operand pairs into it and returns the dot product.
// Optional build macro MAC_DOT_SEQ_SAT_EN clamps the captured result to 16 bits.
module mac_dot_sequencer #(
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mac_clr,
  output logic        mac_en,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  input  logic [23:0] mac_acc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               drain_last_q;
  logic               accept;
  logic               last_pair;
  logic [23:0]        capture;

  assign accept    = in_valid && in_ready;
  assign last_pair = (cnt_q == CNT_W'(VEC_LEN - 1));

`ifdef MAC_DOT_SEQ_SAT_EN
  assign capture = (mac_acc > 24'd65535) ? 24'd65535 : mac_acc;
`else
  assign capture = mac_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mac_clr   = rst;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (in_valid) state_d = CLEAR;
      end
      CLEAR: begin
        mac_clr = 1'b1;
        state_d = FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid && last_pair) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last_q) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mac_en tracks the handshake one cycle late, so it naturally drops in gaps and in the second DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      drain_last_q <= 1'b0;
      mac_en       <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      out_data     <= '0;
    end else begin
      mac_en       <= accept;
      drain_last_q <= (state_q == DRAIN) && !drain_last_q;
      if (state_q == CLEAR) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        mac_a <= in_a;
        mac_b <= in_b;
      end
      if ((state_q == DRAIN) && drain_last_q) begin
        out_data <= capture;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: two instances (VEC_LEN 3 and 1), each with a behavioural mac model and a result scoreboard.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [7:0]  in_a     [2];
  logic [7:0]  in_b     [2];
  logic [1:0]  mac_clr;
  logic [1:0]  mac_en;
  logic [7:0]  mac_a    [2];
  logic [7:0]  mac_b    [2];
  logic [23:0] mac_acc  [2];
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [23:0] out_data [2];
  logic [1:0]  busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned clr_count = 0;
  logic [31:0] exp_sum [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  always #5 clk = ~clk;

  mac_dot_sequencer #(.VEC_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .mac_clr(mac_clr[0]), .mac_en(mac_en[0]), .mac_a(mac_a[0]), .mac_b(mac_b[0]),
    .mac_acc(mac_acc[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  mac_dot_sequencer #(.VEC_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .mac_clr(mac_clr[1]), .mac_en(mac_en[1]), .mac_a(mac_a[1]), .mac_b(mac_b[1]),
    .mac_acc(mac_acc[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  // Behavioural mac: clear wins, otherwise accumulate a*b when enabled.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mac_clr[u]) mac_acc[u] <= 24'd0;
      else if (mac_en[u]) mac_acc[u] <= mac_acc[u] + (24'(mac_a[u]) * 24'(mac_b[u]));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the oldest expected result on every output handshake.
  always @(negedge clk) begin
    if (!rst && mac_clr[1]) clr_count++;
    if (!rst && out_valid[0] && out_ready[0]) begin
      chk("sb0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) chk("sb0_result", 32'(out_data[0]), 32'(q0.pop_front()));
    end
    if (!rst && out_valid[1] && out_ready[1]) begin
      chk("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) chk("sb1_result", 32'(out_data[1]), 32'(q1.pop_front()));
    end
  end

  task automatic send_pair(input int u, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid[u] = 1'b1;
    in_a[u] = a;
    in_b[u] = b;
    @(negedge clk);
    while (!in_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", 32'(in_ready[u]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    exp_sum[u] = exp_sum[u] + 32'(a) * 32'(b);
  endtask

  task automatic push_exp(input int u);
    logic [31:0] v;
    v = exp_sum[u];
`ifdef MAC_DOT_SEQ_SAT_EN
    if (v > 32'd65535) v = 32'd65535;
`endif
    if (u == 0) q0.push_back(v[23:0]);
    else q1.push_back(v[23:0]);
    exp_sum[u] = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int u);
    int n = 0;
    while (!out_valid[u] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("result_seen", 32'(out_valid[u]), 32'd1);
    if (out_ready[u]) idle(1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    for (int u = 0; u < 2; u++) begin
      in_a[u] = '0;
      in_b[u] = '0;
      exp_sum[u] = '0;
    end
    idle(2);
    chk("rst_mac_clr", 32'(mac_clr[0]), 32'd1);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_mac_en", 32'(mac_en[0]), 32'd0);
    chk("rst_mac_a", 32'(mac_a[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_data", 32'(out_data[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    idle(1);

    // Back-to-back vector with latency check
    send_pair(0, 8'd3, 8'd4);
    send_pair(0, 8'd2, 8'd5);
    send_pair(0, 8'd1, 8'd7);
    push_exp(0);
    chk("drain1_mac_en", 32'(mac_en[0]), 32'd1);
    chk("drain1_in_ready", 32'(in_ready[0]), 32'd0);
    chk("drain1_out_valid", 32'(out_valid[0]), 32'd0);
    idle(1);
    chk("drain2_mac_en", 32'(mac_en[0]), 32'd0);
    chk("drain2_out_valid", 32'(out_valid[0]), 32'd0);
    idle(1);
    chk("lat_out_valid", 32'(out_valid[0]), 32'd1);
    chk("lat_out_data", 32'(out_data[0]), 32'd29);
    idle(1);
    chk("after_hs_valid", 32'(out_valid[0]), 32'd0);
    chk("after_hs_busy", 32'(busy[0]), 32'd0);

    // Gapped vector: mac_en drops, counter must not advance in gaps
    send_pair(0, 8'd3, 8'd4);
    chk("gap_en_hi", 32'(mac_en[0]), 32'd1);
    idle(1);
    chk("gap_en_lo", 32'(mac_en[0]), 32'd0);
    chk("gap_ready", 32'(in_ready[0]), 32'd1);
    idle(1);
    send_pair(0, 8'd2, 8'd5);
    idle(2);
    chk("gap_ready2", 32'(in_ready[0]), 32'd1);
    send_pair(0, 8'd1, 8'd7);
    push_exp(0);
    wait_result(0);

    // Back-pressure: result held while out_ready is low
    out_ready[0] = 1'b0;
    send_pair(0, 8'd3, 8'd4);
    send_pair(0, 8'd2, 8'd5);
    send_pair(0, 8'd1, 8'd7);
    push_exp(0);
    wait_result(0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold_valid", 32'(out_valid[0]), 32'd1);
      chk("hold_data", 32'(out_data[0]), 32'd29);
      chk("hold_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    idle(1);
    chk("release_valid", 32'(out_valid[0]), 32'd0);
    chk("release_busy", 32'(busy[0]), 32'd0);

    // Reset in the middle of a vector
    send_pair(0, 8'd9, 8'd9);
    send_pair(0, 8'd9, 8'd9);
    exp_sum[0] = 32'd0;
    rst = 1'b1;
    #1;
    chk("midrst_mac_clr", 32'(mac_clr[0]), 32'd1);
    idle(1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_mac_en", 32'(mac_en[0]), 32'd0);
    chk("midrst_mac_b", 32'(mac_b[0]), 32'd0);
    chk("midrst_out_data", 32'(out_data[0]), 32'd0);
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    idle(1);
    send_pair(0, 8'd1, 8'd1);
    send_pair(0, 8'd1, 8'd1);
    send_pair(0, 8'd1, 8'd1);
    push_exp(0);
    wait_result(0);

    // Largest operands
    send_pair(0, 8'd255, 8'd255);
    send_pair(0, 8'd255, 8'd255);
    send_pair(0, 8'd255, 8'd255);
    push_exp(0);
    wait_result(0);

    // Single-pair vectors on the VEC_LEN=1 instance
    clr_count = 0;
    send_pair(1, 8'd0, 8'd200);
    push_exp(1);
    wait_result(1);
    send_pair(1, 8'd15, 8'd15);
    push_exp(1);
    wait_result(1);
    chk("clr_pulses", 32'(clr_count), 32'd2);

    idle(2);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
